// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and the redirect controller state encoding.
package riscv_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_DRAIN    = 2'd2
   } state_t;

   // Performance counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] val);
      return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational taken evaluation for conditional branches and unconditional jumps.
module branch_cond
   import riscv_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [2:0]  br_type,
   input  logic [6:0]  opcode,
   output logic        taken
);

   always_comb begin
      taken = 1'b0;
      case (opcode)
         OP_BRANCH: begin
            case (br_type)
               F3_BEQ:  taken = (rs1 == rs2);
               F3_BNE:  taken = (rs1 != rs2);
               F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
               F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
               F3_BLTU: taken = (rs1 <  rs2);
               F3_BGEU: taken = (rs1 >= rs2);
               default: taken = 1'b0;
            endcase
         end
         OP_JAL, OP_JALR: taken = 1'b1;
         default:         taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Static not-taken redirect controller: issues a fetch redirect and pipeline
// flushes for every taken branch/jump in EX, and counts branches and redirects.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | watching EX for a taken branch/jump
// ST_REDIRECT | redirect_pc offered to fetch, IF/ID and ID/EX flushed
// ST_DRAIN    | one cycle flushing IF/ID only while fetch restarts
module branch_redirect_ctrl
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [6:0]  ex_opcode,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_rs1,
   input  logic [31:0] ex_rs2,
   input  logic [31:0] ex_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   input  logic        redirect_ready,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        busy,
   input  logic        cnt_clear,
   output logic [31:0] br_count,
   output logic [31:0] taken_count
);

   state_t state;
   logic   taken;
   logic   start;
   logic   br_hit;

   branch_cond u_branch_cond (
      .rs1     (ex_rs1),
      .rs2     (ex_rs2),
      .br_type (ex_funct3),
      .opcode  (ex_opcode),
      .taken   (taken)
   );

   // EX is only trusted in IDLE; anything seen while busy is wrong-path.
   assign start  = (state == ST_IDLE) && ex_valid && taken;
   assign br_hit = (state == ST_IDLE) && ex_valid && (ex_opcode == OP_BRANCH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         redirect_pc <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state       <= ST_REDIRECT;
                  redirect_pc <= ex_target;
               end
            end
            ST_REDIRECT: begin
               if (redirect_ready) state <= ST_DRAIN;
            end
            ST_DRAIN: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_count    <= '0;
         taken_count <= '0;
      end else if (cnt_clear) begin
         br_count    <= '0;
         taken_count <= '0;
      end else begin
         if (br_hit) br_count    <= sat_inc(br_count);
         if (start)  taken_count <= sat_inc(taken_count);
      end
   end

   assign redirect_valid = (state == ST_REDIRECT);
   assign flush_id_ex    = (state == ST_REDIRECT);
   assign flush_if_id    = (state != ST_IDLE);
   assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a vector table plus hand sequences
// for stalled handshakes, counter saturation and mid-redirect reset.
module tb_branch_redirect_ctrl;

   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ALU  = 7'b0110011;
   localparam int SI = 0, SR = 1, SD = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0;
   logic [6:0]  ex_opcode = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_rs1 = '0;
   logic [31:0] ex_rs2 = '0;
   logic [31:0] ex_target = '0;
   logic        redirect_ready = 1'b0;
   logic        cnt_clear = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        flush_if_id;
   logic        flush_id_ex;
   logic        busy;
   logic [31:0] br_count;
   logic [31:0] taken_count;

   int n_checks = 0;
   int n_errors = 0;

   branch_redirect_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_funct3      (ex_funct3),
      .ex_rs1         (ex_rs1),
      .ex_rs2         (ex_rs2),
      .ex_target      (ex_target),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .redirect_ready (redirect_ready),
      .flush_if_id    (flush_if_id),
      .flush_id_ex    (flush_id_ex),
      .busy           (busy),
      .cnt_clear      (cnt_clear),
      .br_count       (br_count),
      .taken_count    (taken_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] tgt;
      logic        rdy;
      logic        clr;
      int          es;
      logic [31:0] e_pc;
      logic [31:0] e_br;
      logic [31:0] e_tk;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] tgt,
                       input logic rdy, input logic clr, input int es,
                       input logic [31:0] e_pc, input logic [31:0] e_br, input logic [31:0] e_tk);
      vec_t r;
      r.v = v; r.op = op; r.f3 = f3; r.rs1 = rs1; r.rs2 = rs2; r.tgt = tgt;
      r.rdy = rdy; r.clr = clr; r.es = es; r.e_pc = e_pc; r.e_br = e_br; r.e_tk = e_tk;
      vecs.push_back(r);
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] tgt,
                        input logic rdy, input logic clr);
      ex_valid = v; ex_opcode = op; ex_funct3 = f3; ex_rs1 = rs1; ex_rs2 = rs2;
      ex_target = tgt; redirect_ready = rdy; cnt_clear = clr;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Expected flag outputs follow directly from the expected state.
   task automatic chk_all(input string tag, input int es, input logic [31:0] pc,
                          input logic [31:0] br, input logic [31:0] tk);
      chk({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(es == SR));
      chk({tag, ".flush_if_id"},    32'(flush_if_id),    32'(es != SI));
      chk({tag, ".flush_id_ex"},    32'(flush_id_ex),    32'(es == SR));
      chk({tag, ".busy"},           32'(busy),           32'(es != SI));
      chk({tag, ".redirect_pc"},    redirect_pc, pc);
      chk({tag, ".br_count"},       br_count, br);
      chk({tag, ".taken_count"},    taken_count, tk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in(input logic rdy);
      drive(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
   endtask

   initial begin
      //    v  op    f3     rs1            rs2    tgt            rdy   clr   es  pc             br            tk
      addv(1, BR,   3'b000, 32'd5,         32'd5, 32'h100,       1'b1, 1'b0, SR, 32'h100,       32'd1,        32'd1);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SD, 32'h100,       32'd1,        32'd1);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SI, 32'h100,       32'd1,        32'd1);
      addv(1, BR,   3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200,       1'b1, 1'b0, SR, 32'h200,       32'd2,        32'd2);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SD, 32'h200,       32'd2,        32'd2);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SI, 32'h200,       32'd2,        32'd2);
      addv(1, BR,   3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300,       1'b1, 1'b0, SI, 32'h200,       32'd3,        32'd2);
      addv(1, ALU,  3'b000, 32'd7,         32'd7, 32'h350,       1'b1, 1'b0, SI, 32'h200,       32'd3,        32'd2);
      addv(1, BR,   3'b010, 32'd7,         32'd7, 32'h360,       1'b1, 1'b0, SI, 32'h200,       32'd4,        32'd2);
      addv(1, BR,   3'b001, 32'd1,         32'd2, 32'h400,       1'b0, 1'b0, SR, 32'h400,       32'd5,        32'd3);
      addv(1, BR,   3'b000, 32'd9,         32'd9, 32'h500,       1'b0, 1'b0, SR, 32'h400,       32'd5,        32'd3);
      addv(1, BR,   3'b000, 32'd9,         32'd9, 32'h500,       1'b1, 1'b0, SD, 32'h400,       32'd5,        32'd3);
      addv(1, BR,   3'b000, 32'd9,         32'd9, 32'h600,       1'b1, 1'b0, SI, 32'h400,       32'd5,        32'd3);
      addv(1, BR,   3'b101, 32'h8000_0000, 32'd0, 32'h650,       1'b1, 1'b0, SI, 32'h400,       32'd6,        32'd3);
      addv(1, BR,   3'b111, 32'h8000_0000, 32'd0, 32'h700,       1'b1, 1'b0, SR, 32'h700,       32'd7,        32'd4);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SD, 32'h700,       32'd7,        32'd4);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SI, 32'h700,       32'd7,        32'd4);
      addv(1, JALR, 3'b000, 32'd0,         32'd0, 32'h800,       1'b1, 1'b0, SR, 32'h800,       32'd7,        32'd5);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SD, 32'h800,       32'd7,        32'd5);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SI, 32'h800,       32'd7,        32'd5);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b1, SI, 32'h800,       32'd0,        32'd0);
      addv(1, JAL,  3'b000, 32'd0,         32'd0, 32'h900,       1'b0, 1'b0, SR, 32'h900,       32'd0,        32'd1);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b0, 1'b1, SR, 32'h900,       32'd0,        32'd0);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SD, 32'h900,       32'd0,        32'd0);
      addv(0, 7'd0, 3'b000, 32'd0,         32'd0, 32'h0,         1'b1, 1'b0, SI, 32'h900,       32'd0,        32'd0);

      #2;
      chk_all("reset", SI, 32'h0, 32'd0, 32'd0);
      tick();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].f3, vecs[i].rs1, vecs[i].rs2,
               vecs[i].tgt, vecs[i].rdy, vecs[i].clr);
         tick();
         chk_all($sformatf("vec%0d", i), vecs[i].es, vecs[i].e_pc, vecs[i].e_br, vecs[i].e_tk);
      end

      // JAL held off by fetch for three cycles, wrong-path taken beq ignored.
      drive(1'b1, JAL, 3'b000, 32'd0, 32'd0, 32'h2000, 1'b0, 1'b0);
      tick();
      chk_all("jal_wait0", SR, 32'h2000, 32'd0, 32'd1);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, BR, 3'b000, 32'd3, 32'd3, 32'h3000, 1'b0, 1'b0);
         tick();
         chk_all($sformatf("jal_wait%0d", k), SR, 32'h2000, 32'd0, 32'd1);
      end
      idle_in(1'b1);
      tick();
      chk_all("jal_drain", SD, 32'h2000, 32'd0, 32'd1);
      tick();
      chk_all("jal_idle", SI, 32'h2000, 32'd0, 32'd1);

      // Counter saturation from preloaded near-full values.
      force dut.br_count = 32'hFFFF_FFFE;
      force dut.taken_count = 32'hFFFF_FFFF;
      #1;
      release dut.br_count;
      release dut.taken_count;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, BR, 3'b001, 32'd4, 32'd4, 32'h3500, 1'b0, 1'b0);
         tick();
         chk_all($sformatf("sat_br%0d", k), SI, 32'h2000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      drive(1'b1, BR, 3'b000, 32'd4, 32'd4, 32'h4000, 1'b1, 1'b0);
      tick();
      chk_all("sat_taken", SR, 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle_in(1'b1);
      tick();
      tick();
      chk_all("sat_back_idle", SI, 32'h4000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      drive(1'b1, BR, 3'b000, 32'd4, 32'd4, 32'h5000, 1'b0, 1'b1);
      tick();
      chk_all("clr_wins", SR, 32'h5000, 32'd0, 32'd0);
      idle_in(1'b1);
      tick();
      tick();
      chk_all("clr_back_idle", SI, 32'h5000, 32'd0, 32'd0);

      // Asynchronous reset in the middle of a stalled redirect.
      drive(1'b1, BR, 3'b000, 32'd6, 32'd6, 32'hABC, 1'b0, 1'b0);
      tick();
      chk_all("pre_rst", SR, 32'hABC, 32'd1, 32'd1);
      idle_in(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", SI, 32'h0, 32'd0, 32'd0);
      tick();
      chk_all("rst_held", SI, 32'h0, 32'd0, 32'd0);
      rst_n = 1'b1;
      drive(1'b1, BR, 3'b000, 32'd6, 32'd6, 32'hDEF, 1'b1, 1'b0);
      tick();
      chk_all("post_rst_redir", SR, 32'hDEF, 32'd1, 32'd1);
      idle_in(1'b1);
      tick();
      chk_all("post_rst_drain", SD, 32'hDEF, 32'd1, 32'd1);
      tick();
      chk_all("post_rst_idle", SI, 32'hDEF, 32'd1, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
